// File: rtl/memshare_delta_reset_gen.sv
// rtl/memshare_delta_reset_gen.sv - per-channel delta-FF reset generator (toggle / pulse modes)
//
// Purpose:
//   Generates one registered synchronous reset per delta-FF channel from the
//   RFMU isGtr event. Each channel works either in toggle mode (reset_o flips
//   on every event) or in pulse mode (reset_o is asserted for PULSE_LEN cycles
//   after an event, retriggerable). Channels are fully independent.
//
// Parameters:
//   CH_NUM        number of channels (1..32)
//   RST_POLARITY  asserted level of reset_o (0 = active low, 1 = active high)
//   PULSE_LEN     pulse-mode assertion length in cycles (1..255)
//
// Ports:
//   sys_clk    in   1         clock, rising edge
//   rstn       in   1         synchronous reset, active HIGH
//   isGtr_i    in   CH_NUM    per-channel isGtr event
//   mode_i     in   CH_NUM    per-channel mode request (0 toggle, 1 pulse)
//   clr_i      in   CH_NUM    per-channel synchronous force-deassert
//   reset_o    out  CH_NUM    registered reset to each delta FF
//   busy_o     out  CH_NUM    channel is in PULSE state
//   evt_cnt_o  out  CH_NUM*8  per-channel saturating event count, channel k at [8k+7:8k]
//
// Configuration:
//   MEMSHARE_DELTA_EVT_CNT_EN  when defined, evt_cnt_o counts accepted events;
//                              otherwise evt_cnt_o is tied to zero.

module memshare_delta_reset_gen #(
  parameter int   CH_NUM       = 4,
  parameter logic RST_POLARITY = 1'b0,
  parameter int   PULSE_LEN    = 2
) (
  input  logic                  sys_clk,
  input  logic                  rstn,
  input  logic [CH_NUM-1:0]     isGtr_i,
  input  logic [CH_NUM-1:0]     mode_i,
  input  logic [CH_NUM-1:0]     clr_i,
  output logic [CH_NUM-1:0]     reset_o,
  output logic [CH_NUM-1:0]     busy_o,
  output logic [CH_NUM*8-1:0]   evt_cnt_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    PULSE = 1'b1
  } state_t;

  localparam logic       RST_ON   = RST_POLARITY;
  localparam logic       RST_OFF  = ~RST_POLARITY;
  // cnt counts the remaining asserted cycles after the current one
  localparam logic [7:0] CNT_LOAD = 8'(PULSE_LEN - 1);

  for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       mode_q, mode_d;
    logic       rst_q, rst_d;

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      rst_d   = rst_q;

      // Mode is only allowed to change between pulses
      if (state_q == IDLE) begin
        mode_d = mode_i[k];
      end

      if (clr_i[k]) begin
        state_d = IDLE;
        cnt_d   = 8'd0;
        rst_d   = RST_OFF;
      end else begin
        case (state_q)
          IDLE: begin
            if (!mode_q) begin
              // Toggle mode: raw XOR, independent of polarity
              rst_d = rst_q ^ isGtr_i[k];
            end else if (isGtr_i[k]) begin
              state_d = PULSE;
              cnt_d   = CNT_LOAD;
              rst_d   = RST_ON;
            end else begin
              rst_d = RST_OFF;
            end
          end
          PULSE: begin
            if (isGtr_i[k]) begin
              // Retrigger keeps reset asserted with no gap
              cnt_d = CNT_LOAD;
              rst_d = RST_ON;
            end else if (cnt_q == 8'd0) begin
              state_d = IDLE;
              rst_d   = RST_OFF;
            end else begin
              cnt_d = cnt_q - 8'd1;
              rst_d = RST_ON;
            end
          end
        endcase
      end
    end

    always_ff @(posedge sys_clk) begin
      if (rstn) begin
        state_q <= IDLE;
        cnt_q   <= 8'd0;
        mode_q  <= 1'b0;
        rst_q   <= RST_ON;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        mode_q  <= mode_d;
        rst_q   <= rst_d;
      end
    end

    assign reset_o[k] = rst_q;
    assign busy_o[k]  = (state_q == PULSE);

`ifdef MEMSHARE_DELTA_EVT_CNT_EN
    logic [7:0] evt_q;

    // An event cancelled by clr_i is not counted; clr_i does not clear the count
    always_ff @(posedge sys_clk) begin
      if (rstn) begin
        evt_q <= 8'd0;
      end else if (isGtr_i[k] && !clr_i[k] && (evt_q != 8'hFF)) begin
        evt_q <= evt_q + 8'd1;
      end
    end

    assign evt_cnt_o[8*k +: 8] = evt_q;
`else
    assign evt_cnt_o[8*k +: 8] = 8'd0;
`endif
  end

endmodule

// File: tb/tb_memshare_delta_reset_gen.sv
// tb/tb_memshare_delta_reset_gen.sv - self-checking bench for memshare_delta_reset_gen

module tb_memshare_delta_reset_gen;

  logic        sys_clk = 1'b0;
  logic        rstn;
  logic [3:0]  isGtr, mode, clr;
  logic [3:0]  reset_a, busy_a, reset_b, busy_b;
  logic [31:0] evt_a, evt_b;

  int checks = 0;
  int errors = 0;

  always #5 sys_clk = ~sys_clk;

  // Instance A: active-low reset, 3-cycle pulse
  memshare_delta_reset_gen #(.CH_NUM(4), .RST_POLARITY(1'b0), .PULSE_LEN(3)) dut_a (
    .sys_clk(sys_clk), .rstn(rstn), .isGtr_i(isGtr), .mode_i(mode), .clr_i(clr),
    .reset_o(reset_a), .busy_o(busy_a), .evt_cnt_o(evt_a)
  );

  // Instance B: active-high reset, 4-cycle pulse
  memshare_delta_reset_gen #(.CH_NUM(4), .RST_POLARITY(1'b1), .PULSE_LEN(4)) dut_b (
    .sys_clk(sys_clk), .rstn(rstn), .isGtr_i(isGtr), .mode_i(mode), .clr_i(clr),
    .reset_o(reset_b), .busy_o(busy_b), .evt_cnt_o(evt_b)
  );

  // Reference model: per channel, remaining asserted cycles of a pulse
  logic [3:0] m_reset [2];
  logic [3:0] m_mode  [2];
  logic [3:0] m_busy  [2];
  int         m_rem   [2][4];
  int         m_evt   [2][4];

  function automatic logic pol_of(int i);
    return (i == 1);
  endfunction

  function automatic int len_of(int i);
    return (i == 0) ? 3 : 4;
  endfunction

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 4; k++) begin
        logic p, g, c, nmode;
        p = pol_of(i);
        g = isGtr[k];
        c = clr[k];
        if (rstn) begin
          m_reset[i][k] = p;
          m_busy[i][k]  = 1'b0;
          m_rem[i][k]   = 0;
          m_mode[i][k]  = 1'b0;
          m_evt[i][k]   = 0;
        end else begin
          nmode = m_busy[i][k] ? m_mode[i][k] : mode[k];
          if (g && !c && m_evt[i][k] < 255) m_evt[i][k]++;
          if (c) begin
            m_reset[i][k] = ~p;
            m_busy[i][k]  = 1'b0;
            m_rem[i][k]   = 0;
          end else if (m_busy[i][k]) begin
            m_rem[i][k] = g ? len_of(i) : m_rem[i][k] - 1;
            if (m_rem[i][k] == 0) m_busy[i][k] = 1'b0;
            m_reset[i][k] = m_busy[i][k] ? p : ~p;
          end else if (m_mode[i][k]) begin
            if (g) begin
              m_busy[i][k]  = 1'b1;
              m_rem[i][k]   = len_of(i);
              m_reset[i][k] = p;
            end else begin
              m_reset[i][k] = ~p;
            end
          end else begin
            m_reset[i][k] = m_reset[i][k] ^ g;
          end
          m_mode[i][k] = nmode;
        end
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_evt(int i);
    logic [31:0] e;
    e = '0;
`ifdef MEMSHARE_DELTA_EVT_CNT_EN
    for (int k = 0; k < 4; k++) e[8*k +: 8] = 8'(m_evt[i][k]);
`endif
    return e;
  endfunction

  task automatic check_model();
    check("model_reset_a", {28'd0, reset_a}, {28'd0, m_reset[0]});
    check("model_busy_a",  {28'd0, busy_a},  {28'd0, m_busy[0]});
    check("model_evt_a",   evt_a,            exp_evt(0));
    check("model_reset_b", {28'd0, reset_b}, {28'd0, m_reset[1]});
    check("model_busy_b",  {28'd0, busy_b},  {28'd0, m_busy[1]});
    check("model_evt_b",   evt_b,            exp_evt(1));
  endtask

  task automatic tick();
    @(posedge sys_clk);
    model_step();
    #1;
    check_model();
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] g;
    logic [3:0] md;
    logic [3:0] cl;
    logic [3:0] exp_reset;
    logic [3:0] exp_busy;
  } vec_t;

  vec_t tbl [22];

  initial begin
    rstn  = 1'b1;
    isGtr = '0;
    mode  = '0;
    clr   = '0;

    // Directed table for instance A; expected outputs after the row's edge
    //            rst   g        mode     clr      reset    busy
    tbl[0]  = '{1'b1, 4'b0000, 4'b1110, 4'b0000, 4'b0000, 4'b0000};
    tbl[1]  = '{1'b0, 4'b0000, 4'b1110, 4'b0000, 4'b0000, 4'b0000};
    tbl[2]  = '{1'b0, 4'b0000, 4'b1110, 4'b0000, 4'b1110, 4'b0000};
    tbl[3]  = '{1'b0, 4'b0001, 4'b1110, 4'b0000, 4'b1111, 4'b0000};
    tbl[4]  = '{1'b0, 4'b0010, 4'b1110, 4'b0000, 4'b1101, 4'b0010};
    tbl[5]  = '{1'b0, 4'b0000, 4'b1110, 4'b0000, 4'b1101, 4'b0010};
    tbl[6]  = '{1'b0, 4'b0001, 4'b1110, 4'b0000, 4'b1100, 4'b0010};
    tbl[7]  = '{1'b0, 4'b1000, 4'b1110, 4'b0000, 4'b0110, 4'b1000};
    tbl[8]  = '{1'b0, 4'b0000, 4'b0110, 4'b0000, 4'b0110, 4'b1000};
    tbl[9]  = '{1'b0, 4'b1000, 4'b0110, 4'b0000, 4'b0110, 4'b1000};
    tbl[10] = '{1'b0, 4'b0000, 4'b0110, 4'b0000, 4'b0110, 4'b1000};
    tbl[11] = '{1'b0, 4'b0000, 4'b0110, 4'b0000, 4'b0110, 4'b1000};
    tbl[12] = '{1'b0, 4'b0000, 4'b0110, 4'b0000, 4'b1110, 4'b0000};
    tbl[13] = '{1'b0, 4'b0000, 4'b0110, 4'b0000, 4'b1110, 4'b0000};
    tbl[14] = '{1'b0, 4'b1000, 4'b0110, 4'b0000, 4'b0110, 4'b0000};
    tbl[15] = '{1'b0, 4'b0100, 4'b0110, 4'b0100, 4'b0110, 4'b0000};
    tbl[16] = '{1'b0, 4'b0100, 4'b0110, 4'b0000, 4'b0010, 4'b0100};
    tbl[17] = '{1'b0, 4'b0100, 4'b0110, 4'b0100, 4'b0110, 4'b0000};
    tbl[18] = '{1'b0, 4'b0010, 4'b0110, 4'b0000, 4'b0100, 4'b0010};
    tbl[19] = '{1'b1, 4'b0000, 4'b0110, 4'b0000, 4'b0000, 4'b0000};
    tbl[20] = '{1'b0, 4'b0010, 4'b0110, 4'b0000, 4'b0010, 4'b0000};
    tbl[21] = '{1'b0, 4'b0000, 4'b0110, 4'b0000, 4'b0110, 4'b0000};

    for (int r = 0; r < 22; r++) begin
      rstn  = tbl[r].rst;
      isGtr = tbl[r].g;
      mode  = tbl[r].md;
      clr   = tbl[r].cl;
      tick();
      check($sformatf("tbl%0d_reset", r), {28'd0, reset_a}, {28'd0, tbl[r].exp_reset});
      check($sformatf("tbl%0d_busy", r),  {28'd0, busy_a},  {28'd0, tbl[r].exp_busy});
    end

    // Randomized traffic against the reference model
    for (int n = 0; n < 3000; n++) begin
      rstn  = ($urandom_range(0, 99) == 0);
      isGtr = 4'($urandom) & 4'($urandom);
      clr   = 4'($urandom) & 4'($urandom) & 4'($urandom) & 4'($urandom);
      if ($urandom_range(0, 7) == 0) mode = 4'($urandom);
      tick();
    end

    // 300 events on channel 3: count saturates (or stays zero without the counter)
    rstn  = 1'b1;
    isGtr = '0;
    clr   = '0;
    mode  = '0;
    tick();
    rstn  = 1'b0;
    isGtr = 4'b1000;
    for (int n = 0; n < 300; n++) tick();
`ifdef MEMSHARE_DELTA_EVT_CNT_EN
    check("evt_sat_ch3", {24'd0, evt_a[31:24]}, 32'd255);
`else
    check("evt_tied_zero", evt_a, 32'd0);
`endif
    check("evt_other_ch", {8'd0, evt_a[23:0]}, 32'd0);

    // Reset during the second cycle of a 4-cycle pulse on instance B
    isGtr = '0;
    rstn  = 1'b1;
    tick();
    rstn  = 1'b0;
    mode  = 4'b0001;
    tick();
    tick();
    check("b_idle_pulse_mode", {28'd0, reset_b}, 32'h0000_000E);
    isGtr = 4'b0001;
    tick();
    check("b_pulse_c1_reset", {28'd0, reset_b}, 32'h0000_000F);
    check("b_pulse_c1_busy",  {28'd0, busy_b},  32'h0000_0001);
    isGtr = 4'b0000;
    tick();
    check("b_pulse_c2_busy",  {28'd0, busy_b},  32'h0000_0001);
    rstn  = 1'b1;
    tick();
    check("b_rst_reset", {28'd0, reset_b}, 32'h0000_000F);
    check("b_rst_busy",  {28'd0, busy_b},  32'h0000_0000);
    check("b_rst_evt",   evt_b,            32'h0000_0000);
    rstn  = 1'b0;
    isGtr = 4'b0001;
    tick();
    check("b_post_rst_toggle", {28'd0, reset_b}, 32'h0000_000E);
    check("b_post_rst_busy",   {28'd0, busy_b},  32'h0000_0000);
    isGtr = 4'b0000;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/memshare_delta_reset_gen.md
MEMSHARE_DELTA_RESET_GEN -- requirements
Module: memshare_delta_reset_gen

Interface
REQ-001 SHALL have parameter CH_NUM, default 4: number of independent delta-FF reset channels (1..32).
REQ-002 SHALL have parameter RST_POLARITY, default 1'b0: asserted level of reset_o; 0 = active LOW, 1 = active HIGH.
REQ-003 SHALL have parameter PULSE_LEN, default 2: pulse-mode assertion length in cycles (1..255).
REQ-004 SHALL have port sys_clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rstn  input  1  synchronous, active-HIGH reset (1 = reset).
REQ-006 SHALL have port isGtr_i  input  CH_NUM  per-channel isGtr event from the RFMU at the SHIFT_GEN state.
REQ-007 SHALL have port mode_i  input  CH_NUM  per-channel mode request: 0 = toggle, 1 = pulse.
REQ-008 SHALL have port clr_i  input  CH_NUM  per-channel synchronous force-deassert.
REQ-009 SHALL have port reset_o  output  CH_NUM  registered synchronous reset to each delta FF.
REQ-010 SHALL have port busy_o  output  CH_NUM  1 while the channel is in PULSE state.
REQ-011 SHALL have port evt_cnt_o  output  CH_NUM*8  per-channel event count; channel k at bits [8k+7:8k].

Function
REQ-012 SHALL implement each channel independently, with no cross-channel interaction.
REQ-013 SHALL register mode_i into mode_q[k] every cycle the channel is in IDLE, and SHALL ignore mode_i while in PULSE.
REQ-014 SHALL, in toggle mode (mode_q=0), drive reset_o[k] <= reset_o[k] XOR isGtr_i[k], i.e. one cycle of latency, with the FSM held in IDLE.
REQ-015 SHALL use a pulse-mode FSM (mode_q=1) with states IDLE and PULSE, plus an 8-bit down-counter cnt.
REQ-016 SHALL, in IDLE, hold reset_o[k] at the deasserted level (~RST_POLARITY); a mode_q change from 0 to 1 deasserts reset_o on the cycle after mode_q updates.
REQ-017 SHALL, on isGtr_i[k]=1 in IDLE at cycle t: enter PULSE, load cnt=PULSE_LEN-1, assert reset_o at t+1..t+PULSE_LEN and deassert it at t+PULSE_LEN+1.
REQ-018 SHALL, in PULSE, decrement cnt each cycle and return to IDLE when cnt=0 and isGtr_i=0.
REQ-019 SHALL, on isGtr_i=1 in PULSE (including the cnt=0 cycle), retrigger: reload cnt=PULSE_LEN-1, stay in PULSE, and keep reset_o asserted continuously.
REQ-020 SHALL drive busy_o[k]=1 exactly when the state is PULSE.
REQ-021 SHALL, when clr_i[k]=1, on the next edge drive reset_o[k] deasserted, state IDLE, cnt=0; clr_i beats a simultaneous isGtr_i, and the event is not counted.
REQ-022 SHALL apply priority rstn > clr_i > isGtr_i.

Reset
REQ-023 SHALL, with rstn=1 at an edge, set every reset_o[k]=RST_POLARITY (asserted), state IDLE, cnt=0, mode_q=0, busy_o=0, evt_cnt_o=0.
REQ-024 SHALL, when rstn is applied mid-pulse, abort the pulse immediately; the first post-reset cycle is IDLE in toggle mode.

Configuration
REQ-025 SHALL, with macro MEMSHARE_DELTA_EVT_CNT_EN defined, increment evt_cnt_o[k] by 1 per accepted isGtr_i[k]=1 cycle, saturating at 255, cleared by rstn only (not by clr_i).
REQ-026 SHALL, without MEMSHARE_DELTA_EVT_CNT_EN, keep the evt_cnt_o port and tie it to 0, with no counter logic.

Verification
REQ-027 SHALL cover: RST_POLARITY=0, toggle mode, rstn then isGtr_i[0] pulses at cycles 3 and 6 -> reset_o[0] is 0 after reset, 1 from cycle 4, 0 from cycle 7.
REQ-028 SHALL cover: PULSE_LEN=3, mode_i[1]=1, isGtr_i[1] at cycle 10 -> reset_o[1] asserted cycles 11-13, deasserted at 14; busy_o[1] high cycles 11-13.
REQ-029 SHALL cover: PULSE_LEN=3, retrigger isGtr_i at cycles 10 and 12 -> reset_o asserted cycles 11-15 with no gap; mode_i toggled at cycle 12 has no effect until IDLE.
REQ-030 SHALL cover: clr_i[2] and isGtr_i[2] both high at cycle 20 in pulse mode -> reset_o[2] deasserted at 21, busy_o=0, evt_cnt_o[2] unchanged.
REQ-031 SHALL cover: with MEMSHARE_DELTA_EVT_CNT_EN, 300 isGtr_i[3] events -> evt_cnt_o[3]=255; rebuilt without the macro -> evt_cnt_o all 0.
REQ-032 SHALL cover: rstn asserted at the second cycle of a PULSE_LEN=4 pulse -> all outputs at reset values the next cycle, and toggle behaviour thereafter.
